hier_path_decoder: RTL and testbench

Receiving end of the hierarchy-path select stream used by the generated module trees.
- Accepts a serialized path, one index digit per handshake, root level first.
- Checks the first DEPTH digits against a fixed prefix, which identifies this subtree node.
- Decodes the final digit into a one-hot select of the node's FANOUT child instances.
- Sits at the subtree root, between the path-stream producer and the child-instance enables.

---
 rtl/hier_path_pkg.sv | 16 +
 rtl/hier_prefix_match.sv | 32 +++
 rtl/hier_path_decoder.sv | 120 ++++++++++++
 tb/tb_hier_path_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hier_path_pkg.sv
// Shared types and defaults for the hierarchy-path select decoder.
package hier_path_pkg;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_DEPTH  = 19;
  localparam int DEF_FANOUT = 10;
  localparam int PFX_MAX_W  = 256;

  typedef enum logic [1:0] {MATCH, HOLD, DRAIN} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISMATCH, ERR_SHORT, ERR_RANGE} err_code_e;

  // Digit for root-first level `level` of a depth-`depth` prefix; caller keeps level < depth.
  function automatic logic [DEF_IDX_W-1:0] prefix_digit(input logic [PFX_MAX_W-1:0] prefix,
                                                         input int depth, input int level);
    return DEF_IDX_W'(prefix >> (DEF_IDX_W * (depth - 1 - level)));
  endfunction
endpackage

// File: rtl/hier_prefix_match.sv
// Level counter plus combinational compare of the incoming digit against the node prefix.
module hier_prefix_match
  import hier_path_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [DEPTH*IDX_W-1:0] PREFIX = '0,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [IDX_W-1:0] digit,
  output logic [LVL_W-1:0] level,
  output logic             at_leaf,
  output logic             match
);
  logic [LVL_W-1:0] lvl_idx;

  assign at_leaf = (level == LVL_W'(DEPTH));
  // Park the index at 0 on the leaf so the prefix shift never goes negative.
  assign lvl_idx = at_leaf ? '0 : level;
  assign match   = !at_leaf &&
                   (digit == IDX_W'(prefix_digit(PFX_MAX_W'(PREFIX), DEPTH, int'(lvl_idx))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                level <= '0;
    else if (clr)              level <= '0;
    else if (inc && !at_leaf)  level <= level + 1'b1;
  end
endmodule

// File: rtl/hier_path_decoder.sv
// Subtree-root path decoder: prefix check, leaf digit -> one-hot child select.
// Optional counters enabled by HIER_PATH_DECODER_STATS_EN.
module hier_path_decoder
  import hier_path_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FANOUT = DEF_FANOUT,
  parameter int IDX_W  = DEF_IDX_W,
  parameter logic [DEPTH*IDX_W-1:0] PREFIX = {{17{4'd0}}, 4'd1, 4'd5}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_digit,
  input  logic              in_last,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic [FANOUT-1:0] sel_onehot,
  output logic              err,
  output logic [1:0]        err_code
`ifdef HIER_PATH_DECODER_STATS_EN
  ,
  output logic [15:0]       stat_ok,
  output logic [15:0]       stat_err
`endif
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  state_e            state, state_n;
  err_code_e         code_q, code_n;
  logic              err_n, sv_n, ret_q, ret_n;
  logic [FANOUT-1:0] oh_n;
  logic              inc, clr, at_leaf, match, acc, leaf_ok;
  logic [LVL_W-1:0]  level;

  hier_prefix_match #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREFIX(PREFIX), .LVL_W(LVL_W)) u_pm (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .digit(in_digit),
    .level(level), .at_leaf(at_leaf), .match(match)
  );

  // One dead cycle after a select handshake before digits are taken again.
  assign in_ready = (state != HOLD) && !ret_q;
  assign acc      = in_valid && in_ready;
  assign leaf_ok  = ({1'b0, in_digit} < (IDX_W + 1)'(FANOUT));
  assign err_code = code_q;

  always_comb begin
    state_n = state;
    code_n  = code_q;
    err_n   = 1'b0;
    sv_n    = sel_valid;
    oh_n    = sel_onehot;
    ret_n   = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    case (state)
      MATCH: if (acc) begin
        if (!at_leaf) begin
          if (!match) begin
            err_n = 1'b1; code_n = ERR_MISMATCH; clr = 1'b1;
            state_n = in_last ? MATCH : DRAIN;
          end else if (in_last) begin
            err_n = 1'b1; code_n = ERR_SHORT; clr = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end else begin
          clr = 1'b1;
          if (!leaf_ok || !in_last) begin
            err_n = 1'b1; code_n = ERR_RANGE;
            state_n = in_last ? MATCH : DRAIN;
          end else begin
            state_n = HOLD;
            sv_n    = 1'b1;
            oh_n    = FANOUT'(1) << in_digit;
          end
        end
      end
      DRAIN: if (acc && in_last) state_n = MATCH;
      HOLD: if (sel_ready) begin
        sv_n = 1'b0; oh_n = '0; clr = 1'b1; ret_n = 1'b1;
        state_n = MATCH;
      end
      default: state_n = MATCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MATCH;
      code_q     <= ERR_NONE;
      err        <= 1'b0;
      sel_valid  <= 1'b0;
      sel_onehot <= '0;
      ret_q      <= 1'b0;
    end else begin
      state      <= state_n;
      code_q     <= code_n;
      err        <= err_n;
      sel_valid  <= sv_n;
      sel_onehot <= oh_n;
      ret_q      <= ret_n;
    end
  end

`ifdef HIER_PATH_DECODER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else begin
      if (sel_valid && sel_ready && stat_ok != 16'hFFFF) stat_ok  <= stat_ok + 16'd1;
      if (err && stat_err != 16'hFFFF)                   stat_err <= stat_err + 16'd1;
    end
  end
`endif

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n) level <= LVL_W'(DEPTH));
endmodule

// File: tb/tb_hier_path_decoder.sv
// Directed bench for hier_path_decoder with a path-level reference model and per-cycle compare.
module tb_hier_path_decoder;
  localparam int DEPTH = 19, FANOUT = 10, IDX_W = 4;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              in_valid = 1'b0, in_last = 1'b0, sel_ready = 1'b0;
  logic [IDX_W-1:0]  in_digit = '0;
  logic              in_ready, sel_valid, err;
  logic [FANOUT-1:0] sel_onehot;
  logic [1:0]        err_code;
`ifdef HIER_PATH_DECODER_STATS_EN
  logic [15:0]       stat_ok, stat_err;
`endif

  hier_path_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .sel_onehot(sel_onehot), .err(err), .err_code(err_code)
`ifdef HIER_PATH_DECODER_STATS_EN
    , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int pfx[DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks where we are in the current path, what the node expects next.
  // mode: 0 taking digits, 1 discarding rest of a bad path, 2 select pending, 3 post-select gap
  int                m_mode = 0, m_pos = 0;
  logic              e_ready = 1'b1, e_sv = 1'b0, e_err = 1'b0;
  logic [FANOUT-1:0] e_oh = '0;
  logic [1:0]        e_code = 2'd0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_pos = 0; e_sv = 0; e_oh = '0; e_err = 0; e_code = 0;
      end else begin
        e_err = 0;
        if (m_mode == 0 && in_valid) begin
          if (m_pos < DEPTH && int'(in_digit) != pfx[m_pos]) begin
            e_err = 1; e_code = 1; m_pos = 0; m_mode = in_last ? 0 : 1;
          end else if (m_pos < DEPTH && in_last) begin
            e_err = 1; e_code = 2; m_pos = 0;
          end else if (m_pos < DEPTH) begin
            m_pos++;
          end else begin
            m_pos = 0;
            if (int'(in_digit) >= FANOUT || !in_last) begin
              e_err = 1; e_code = 3; m_mode = in_last ? 0 : 1;
            end else begin
              m_mode = 2; e_sv = 1; e_oh = '0; e_oh[in_digit] = 1'b1;
            end
          end
        end else if (m_mode == 1) begin
          if (in_valid && in_last) m_mode = 0;
        end else if (m_mode == 2) begin
          if (sel_ready) begin m_mode = 3; e_sv = 0; e_oh = '0; end
        end else if (m_mode == 3) begin
          m_mode = 0;
        end
      end
      e_ready = (m_mode == 0 || m_mode == 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, e_ready);
        chk("sel_valid", sel_valid, e_sv);
        chk("sel_onehot", sel_onehot, e_oh);
        chk("err", err, e_err);
        chk("err_code", err_code, e_code);
      end
    end
  end

  // In-ready low-run monitor for the back-to-back test.
  bit gap_on = 0;
  int gap_run = 0, sel_cnt = 0;
  int gaps[$];
  initial begin
    forever begin
      @(negedge clk);
      if (gap_on) begin
        if (sel_valid && sel_ready) sel_cnt++;
        if (!in_ready) gap_run++;
        else if (gap_run > 0) begin gaps.push_back(gap_run); gap_run = 0; end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input int d, input bit last);
    bit rdy;
    int budget = 50;
    in_valid = 1'b1; in_digit = IDX_W'(d); in_last = last;
    do begin
      rdy = in_ready;
      @(posedge clk); #2;
      budget--;
    end while (!rdy && budget > 0);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0; in_digit = '0;
  endtask

  task automatic send_prefix(input int n);
    for (int k = 0; k < n; k++) send(pfx[k], 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rst_ready"}, in_ready, 1);
    chk({tag, "_rst_sv"}, sel_valid, 0);
    chk({tag, "_rst_oh"}, sel_onehot, 0);
    chk({tag, "_rst_err"}, err, 0);
    chk({tag, "_rst_code"}, err_code, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) pfx[k] = 0;
    pfx[17] = 1; pfx[18] = 5;
    #1 reset_checks("init");
    #16 rst_n = 1'b1;
    cyc(1);

    // Basic decode, consumer stalls three cycles.
    send_prefix(DEPTH); send(7, 1'b1); idle();
    for (int i = 0; i < 4; i++) begin
      chk("t1_sv", sel_valid, 1);
      chk("t1_oh", sel_onehot, 32'b0010000000);
      chk("t1_ready", in_ready, 0);
      if (i < 3) cyc(1);
    end
    sel_ready = 1'b1; cyc(1); sel_ready = 1'b0;
    chk("t1_sv_drop", sel_valid, 0);
    chk("t1_gap", in_ready, 0);
    cyc(1);
    chk("t1_back", in_ready, 1);

    // Mismatch at level 2, drained path.
    send(0, 0); send(0, 0); send(3, 0);
    for (int i = 0; i < 4; i++) send(i + 1, 0);
    send(2, 1); idle(); cyc(1);
    chk("t2_code", err_code, 1);

    // Short path, then a good one.
    send_prefix(DEPTH - 1); send(pfx[DEPTH-1], 1'b1); idle(); cyc(1);
    chk("t3_code", err_code, 2);
    sel_ready = 1'b1;
    send_prefix(DEPTH); send(4, 1'b1); idle();
    chk("t3_oh", sel_onehot, 32'b0000010000);
    cyc(2);

    // Leaf out of range, then path too long, then a good leaf 9.
    send_prefix(DEPTH); send(12, 1'b1); idle(); cyc(1);
    chk("t4_range", err_code, 3);
    send_prefix(DEPTH); send(3, 1'b0); send(2, 1'b1); idle(); cyc(1);
    chk("t4_long", err_code, 3);
    send_prefix(DEPTH); send(9, 1'b1); idle();
    chk("t4_oh9", sel_onehot, 32'b1000000000);
    cyc(2);

    // Reset mid-path, then during HOLD.
    send_prefix(10); idle();
    #1 rst_n = 1'b0;
    #1 reset_checks("midpath");
    @(negedge clk); rst_n = 1'b1;
    cyc(1);
    sel_ready = 1'b0;
    send_prefix(DEPTH); send(2, 1'b1); idle();
    chk("t5_oh2", sel_onehot, 32'b0000000100);
    cyc(1);
    #1 rst_n = 1'b0;
    #1 reset_checks("hold");
    @(negedge clk); rst_n = 1'b1;
    cyc(1);
    sel_ready = 1'b1;
    send_prefix(DEPTH); send(6, 1'b1); idle();
    chk("t5_oh6", sel_onehot, 32'b0001000000);
    cyc(2);

    // Back-to-back paths, continuous valid.
    gap_on = 1;
    for (int p = 0; p < 4; p++) begin send_prefix(DEPTH); send(p * 2 + 1, 1'b1); end
    idle(); cyc(4);
    gap_on = 0;
    chk("t6_sel_cnt", sel_cnt, 4);
    chk("t6_gap_cnt", gaps.size(), 4);
    foreach (gaps[i]) chk("t6_gap_len", gaps[i], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
